// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry, parity constants.
// Used by both uart_tx and the matching receiver so framing stays identical.
// Optional feature macro: UART_TX_TWO_STOP_EN (adds STOP2 state in uart_tx).
package uart_pkg;

   localparam int DATA_BITS   = 8;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BITS  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4,
      STOP2 = 3'd5
   } uart_state_e;

   // clk cycles per bit period; integer division, so the line rate rounds up slightly
   function automatic int calc_baud_clocks(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: counts 0..CLOCKS-1, done is high during the terminal count cycle.
// clr holds the count at zero; reaching terminal count wraps to zero on the next edge.
// Shared with the receiver, which uses the same clear/terminal-count handshake.
module uart_baud_timer #(
   parameter int CLOCKS = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic done
);

   localparam int            W    = (CLOCKS > 1) ? $clog2(CLOCKS) : 1;
   localparam logic [W-1:0]  TERM = W'(CLOCKS - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // terminal-count detect and next count
   always_comb begin
      done  = (cnt_q == TERM);
      cnt_d = (clr || done) ? '0 : cnt_q + 1'b1;
   end

   // count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB-first, parity, stop; every output registered.
// Accept latency 1 clk from send in IDLE; each bit lasts BAUD_CLOCKS clks; send ignored while busy.
// Macro UART_TX_TWO_STOP_EN adds a second stop bit (STOP2); busy/tx_done then clear after it.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQUENCY = 100000000,
   parameter int BAUD_RATE     = 19200,
   parameter int PARITY_MODE   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send,
   input  logic [7:0] din,
   output logic       tx_out,
   output logic       busy,
   output logic       tx_done
);

   localparam int                 BAUD_CLOCKS = calc_baud_clocks(CLK_FREQUENCY, BAUD_RATE);
   localparam int                 CNT_W       = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0]   BIT_LAST    = CNT_W'(DATA_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 par_q, par_d;
   logic                 tx_out_q, tx_out_d;
   logic                 busy_q, busy_d;
   logic                 tx_done_q, tx_done_d;
   logic                 tmr_clr;
   logic                 bit_end;

   uart_baud_timer #(.CLOCKS(BAUD_CLOCKS)) u_baud_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (tmr_clr),
      .done (bit_end)
   );

   // next-state logic; tx_out_d is the line level for the state being entered
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      par_d     = par_q;
      tx_out_d  = tx_out_q;
      busy_d    = busy_q;
      tx_done_d = 1'b0;
      tmr_clr   = 1'b0;
      case (state_q)
         IDLE: begin
            tmr_clr  = 1'b1;
            tx_out_d = 1'b1;
            busy_d   = 1'b0;
            if (send) begin
               shift_d  = din;
               par_d    = (PARITY_MODE == PARITY_ODD) ? ~^din : ^din;
               busy_d   = 1'b1;
               tx_out_d = 1'b0;
               state_d  = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = BITS;
               bit_cnt_d = '0;
               tx_out_d  = shift_q[0];
            end
         end
         BITS: begin
            if (bit_end) begin
               shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d  = PAR;
                  tx_out_d = par_q;
               end else begin
                  tx_out_d = shift_q[1];
               end
            end
         end
         PAR: begin
            if (bit_end) begin
               state_d  = STOP;
               tx_out_d = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               tx_out_d = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
               state_d   = STOP2;
`else
               state_d   = IDLE;
               busy_d    = 1'b0;
               tx_done_d = 1'b1;
`endif
            end
         end
`ifdef UART_TX_TWO_STOP_EN
         STOP2: begin
            if (bit_end) begin
               tx_out_d  = 1'b1;
               state_d   = IDLE;
               busy_d    = 1'b0;
               tx_done_d = 1'b1;
            end
         end
`endif
         default: begin
            state_d  = IDLE;
            tx_out_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   // state and datapath registers; reset aborts any frame with the line high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_q     <= 1'b0;
         tx_out_q  <= 1'b1;
         busy_q    <= 1'b0;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         par_q     <= par_d;
         tx_out_q  <= tx_out_d;
         busy_q    <= busy_d;
         tx_done_q <= tx_done_d;
      end
   end

   assign tx_out  = tx_out_q;
   assign busy    = busy_q;
   assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: odd- and even-parity instances driven in parallel.
// Scaled clock/baud (16 clks per bit) keeps frames short; every line cycle is checked.
// Frame length follows UART_TX_TWO_STOP_EN when the macro is defined.
module tb_uart_tx;

   localparam int CLK_F = 160;
   localparam int BAUD  = 10;
   localparam int B     = 16;
`ifdef UART_TX_TWO_STOP_EN
   localparam int NBITS = 12;
`else
   localparam int NBITS = 11;
`endif
   localparam int FRAME = NBITS * B;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       send = 1'b0;
   logic [7:0] din  = 8'h00;
   logic       tx_o, busy_o, done_o;
   logic       tx_e, busy_e, done_e;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] d;
      logic       po;   // expected parity bit, odd mode
      logic       pe;   // expected parity bit, even mode
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   uart_tx #(.CLK_FREQUENCY(CLK_F), .BAUD_RATE(BAUD), .PARITY_MODE(1)) dut_odd (
      .clk(clk), .rst(rst), .send(send), .din(din),
      .tx_out(tx_o), .busy(busy_o), .tx_done(done_o)
   );

   uart_tx #(.CLK_FREQUENCY(CLK_F), .BAUD_RATE(BAUD), .PARITY_MODE(0)) dut_even (
      .clk(clk), .rst(rst), .send(send), .din(din),
      .tx_out(tx_e), .busy(busy_e), .tx_done(done_e)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h", nm, got, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] d, input logic par, input int i);
      if (i == 0)      return 1'b0;
      else if (i <= 8) return d[i-1];
      else if (i == 9) return par;
      else             return 1'b1;
   endfunction

   // Starts at a negedge with the DUT idle; returns at the negedge of the idle cycle after the frame.
   task automatic check_frame(input string nm, input logic [7:0] d, input logic po, input logic pe,
                              input bit hold, input logic [7:0] next_din,
                              input bit poke, input logic [7:0] poke_din);
      int eo = 0, ee = 0, eb = 0, ed = 0;
      din  = d;
      send = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din  = next_din;
      send = hold;
      for (int k = 0; k < FRAME; k++) begin
         if (tx_o !== exp_bit(d, po, k / B)) eo++;
         if (tx_e !== exp_bit(d, pe, k / B)) ee++;
         if (busy_o !== 1'b1 || busy_e !== 1'b1) eb++;
         if (done_o !== 1'b0 || done_e !== 1'b0) ed++;
         if (poke) begin
            if (k == FRAME / 2) begin
               send = 1'b1;
               din  = poke_din;
            end else if (k == FRAME / 2 + 1) begin
               send = 1'b0;
            end
         end
         @(negedge clk);
      end
      chk({nm, "_bits_odd"}, eo, 0);
      chk({nm, "_bits_even"}, ee, 0);
      chk({nm, "_busy_len"}, eb, 0);
      chk({nm, "_done_early"}, ed, 0);
      chk({nm, "_end"}, {26'd0, tx_o, tx_e, busy_o, busy_e, done_o, done_e}, 32'b110011);
   endtask

   initial begin
      int errs;
      vecs[0] = '{8'h41, 1'b1, 1'b0};
      vecs[1] = '{8'hFF, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 1'b1, 1'b0};
      vecs[3] = '{8'h5A, 1'b1, 1'b0};
      vecs[4] = '{8'h80, 1'b0, 1'b1};
      vecs[5] = '{8'h07, 1'b0, 1'b1};
      vecs[6] = '{8'hFE, 1'b0, 1'b1};
      vecs[7] = '{8'h3C, 1'b1, 1'b0};

      // reset state
      repeat (3) @(negedge clk);
      chk("reset_state", {26'd0, tx_o, tx_e, busy_o, busy_e, done_o, done_e}, 32'b110000);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_after_reset", {26'd0, tx_o, tx_e, busy_o, busy_e, done_o, done_e}, 32'b110000);

      // single frames from the table, din scrambled after capture
      for (int i = 0; i < 8; i++) begin
         check_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].po, vecs[i].pe,
                     1'b0, ~vecs[i].d, 1'b0, 8'h00);
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), {28'd0, done_o, done_e, tx_o, tx_e}, 32'b0011);
         repeat (2) @(negedge clk);
      end

      // send held high: 00 then FF, one idle clk between frames
      check_frame("hold0", 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
      check_frame("hold1", 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      repeat (2) @(negedge clk);

      // second request mid-frame must be dropped
      check_frame("poke", 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h3C);
      errs = 0;
      for (int k = 0; k < 3 * B; k++) begin
         @(negedge clk);
         if (tx_o !== 1'b1 || tx_e !== 1'b1 || busy_o !== 1'b0 || busy_e !== 1'b0) errs++;
      end
      chk("poke_idle_after", errs, 0);

      // reset in the middle of data bit 4
      din  = 8'h33;
      send = 1'b1;
      @(posedge clk);
      @(negedge clk);
      send = 1'b0;
      din  = 8'h00;
      repeat (5 * B + B / 2) @(negedge clk);
      chk("pre_reset_busy", {30'd0, busy_o, busy_e}, 32'b11);
      #1 rst = 1'b1;
      #1 chk("reset_abort", {26'd0, tx_o, tx_e, busy_o, busy_e, done_o, done_e}, 32'b110000);
      errs = 0;
      repeat (3) begin
         @(negedge clk);
         if (done_o !== 1'b0 || done_e !== 1'b0 || tx_o !== 1'b1 || tx_e !== 1'b1) errs++;
      end
      rst = 1'b0;
      for (int k = 0; k < 2 * B; k++) begin
         @(negedge clk);
         if (done_o !== 1'b0 || done_e !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) errs++;
      end
      chk("reset_no_done", errs, 0);
      check_frame("after_reset", 8'h55, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, 8'h00);
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
